// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the pooling engine.
// Imported by the line buffer and the top level.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Wide enough to hold the sum of a full P x P window.
  function automatic int acc_w(input int dw, input int p);
    return dw + 2 * clog2(p);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Per-window partial results carried between rows of a band.
// Synchronous write, combinational read, no reset on storage.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 10,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_row_unit.sv
// P x P max/average pooling over a raster pixel stream.
// One pixel per enabled cycle, one result per complete window.
module pool_row_unit
  import pool_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int P     = 2
) (
  input  logic          clk,
  input  logic          master_rst,
  input  logic          ce,
  input  logic [DW-1:0] din,
  input  logic          avg_mode,
  output logic [DW-1:0] dout,
  output logic          op_en,
  output logic          end_op,
  output logic          busy
);

  localparam int LP    = clog2(P);
  localparam int ACC_W = acc_w(DW, P);
  localparam int OW    = IMG_W / P;
  localparam int OH    = IMG_H / P;
  localparam int CW    = clog2(IMG_W);
  localparam int RW    = clog2(IMG_H);
  localparam int WCW   = (clog2(OW) < 1) ? 1 : clog2(OW);

  localparam logic [CW:0] COL_LIM = (CW+1)'(OW * P);
  localparam logic [RW:0] ROW_LIM = (RW+1)'(OH * P);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [ACC_W-1:0] r_acc;
  logic             r_mode;
  logic [DW-1:0]    r_dout;
  logic             r_op_en;
  logic             r_end_op;
  logic             r_busy;

  logic [LP-1:0]    w_cx;
  logic [LP-1:0]    w_ry;
  logic [WCW-1:0]   w_wc;
  logic             w_first;
  logic             w_mode;
  logic             w_active;
  logic             w_acc_en;
  logic             w_win_done;
  logic             w_lb_we;
  logic             w_frame_last;
  logic             w_last_win;
  logic [ACC_W-1:0] w_din_x;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_lbuf_rd;
  logic [ACC_W-1:0] w_comb;
  logic [DW-1:0]    w_res;

  assign w_cx     = r_col[LP-1:0];
  assign w_ry     = r_row[LP-1:0];
  assign w_wc     = WCW'(r_col >> LP);
  assign w_first  = (r_col == '0) && (r_row == '0);
  assign w_mode   = w_first ? avg_mode : r_mode;
  assign w_active = ({1'b0, r_col} < COL_LIM)
                 && ({1'b0, r_row} < ROW_LIM);

  assign w_acc_en   = ce & w_active;
  assign w_win_done = w_acc_en & (&w_cx) & (&w_ry);
  assign w_lb_we    = w_acc_en & (&w_cx) & ~(&w_ry);

  assign w_frame_last = (r_col == CW'(IMG_W - 1))
                     && (r_row == RW'(IMG_H - 1));
  assign w_last_win   = (r_col == CW'(OW * P - 1))
                     && (r_row == RW'(OH * P - 1));

  assign w_din_x = ACC_W'(din);
  assign w_base  = (w_cx == '0) ? w_lbuf_rd : r_acc;

  always_comb begin
    w_comb = w_din_x;
    if (!((w_cx == '0) && (w_ry == '0))) begin
      if (w_mode == POOL_AVG)
        w_comb = w_base + w_din_x;
      else
        w_comb = (w_base > w_din_x) ? w_base : w_din_x;
    end
  end

  // Average divides by P*P, i.e. drops the low 2*LP bits.
  assign w_res = (w_mode == POOL_AVG) ? w_comb[2*LP +: DW]
                                      : w_comb[DW-1:0];

  pool_line_buf #(
    .DEPTH (OW),
    .WIDTH (ACC_W),
    .AW    (WCW)
  ) u_lbuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_wc),
    .i_wdata (w_comb),
    .i_raddr (w_wc),
    .o_rdata (w_lbuf_rd)
  );

  always_ff @(posedge clk) begin
    if (master_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (ce) begin
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        if (r_row == RW'(IMG_H - 1)) r_row <= '0;
        else                         r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      r_acc  <= '0;
      r_mode <= POOL_MAX;
    end else if (ce) begin
      if (w_first)  r_mode <= avg_mode;
      if (w_active) r_acc  <= w_comb;
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      r_dout   <= '0;
      r_op_en  <= 1'b0;
      r_end_op <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_op_en  <= w_win_done;
      r_end_op <= w_win_done & w_last_win;
      if (w_win_done) r_dout <= w_res;
      if (ce)         r_busy <= ~w_frame_last;
    end
  end

  assign dout   = r_dout;
  assign op_en  = r_op_en;
  assign end_op = r_end_op;
  assign busy   = r_busy;

endmodule
